// File: rtl/painel_pkg.sv
// Shared types and sizes for the LED matrix column scanner.
// Holds scan states, panel geometry and counter sizing.
package painel_pkg;

  localparam int NUM_COL = 7;
  localparam int ROW_W   = 7;
  localparam int SEL_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_SHOW
  } estado_t;

  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/controlador_varredura_if.sv
// Control/data bundle between the host and the column scanner.
// Host writes the back buffer; scanner drives the column decoder.
interface controlador_varredura_if;
  import painel_pkg::*;

  logic             en;
  logic             wr_en;
  logic [SEL_W-1:0] wr_col;
  logic [ROW_W-1:0] wr_data;
  logic             swap_req;
  logic [SEL_W-1:0] sel;
  logic [ROW_W-1:0] linhas;
  logic             blank;
  logic             frame_start;
  logic             swap_pend;

  modport master (
    output en, wr_en, wr_col, wr_data, swap_req,
    input  sel, linhas, blank, frame_start, swap_pend
  );

  modport slave (
    input  en, wr_en, wr_col, wr_data, swap_req,
    output sel, linhas, blank, frame_start, swap_pend
  );

endinterface

// File: rtl/contador_tempo.sv
// Loadable down-counter timing the blank and dwell phases.
// tc_o is high while the count sits at zero.
module contador_tempo #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load takes priority; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/controlador_varredura.sv
// Column scanner for a 7x7 LED matrix with double-buffered rows.
// Front buffer is replaced from back only at the column 6->0 wrap.
module controlador_varredura
  import painel_pkg::*;
#(
  parameter int DWELL = 1000,
  parameter int BLANK = 4
) (
  input logic clk,
  input logic rst_n,
  controlador_varredura_if.slave bus
);

  localparam int CW = cnt_w(DWELL, BLANK);
  localparam logic [CW-1:0] LD_SHOW  = CW'(DWELL - 1);
  localparam logic [CW-1:0] LD_BLANK = CW'(BLANK - 1);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM_COL - 1);

  estado_t          state_q, state_d;
  logic [SEL_W-1:0] col_q, col_d;
  logic             load;
  logic [CW-1:0]    load_val;
  logic             tc;
  logic             wrap;
  logic             do_swap;

  logic [ROW_W-1:0] front_q [NUM_COL];
  logic [ROW_W-1:0] back_q  [NUM_COL];

  logic             swap_pend_q, swap_pend_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [ROW_W-1:0] linhas_q, linhas_d;
  logic             blank_q, blank_d;
  logic             fs_q, fs_d;

  contador_tempo #(.W(CW)) u_tempo (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .load_val_i (load_val),
    .tc_o       (tc)
  );

  assign wrap    = bus.en && state_q == ST_SHOW
                && tc && col_q == LAST;
  assign do_swap = wrap && swap_pend_q;

  // Next state and next registered outputs, decoded from next state.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    load     = 1'b0;
    load_val = '0;
    sel_d    = '0;
    linhas_d = '0;
    blank_d  = 1'b1;
    fs_d     = 1'b0;
    if (!bus.en) begin
      state_d = ST_IDLE;
      col_d   = '0;
      load    = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d  = ST_BLANK;
          load     = 1'b1;
          load_val = LD_BLANK;
        end
        ST_BLANK: begin
          if (tc) begin
            state_d  = ST_SHOW;
            load     = 1'b1;
            load_val = LD_SHOW;
          end
        end
        ST_SHOW: begin
          if (tc) begin
            state_d  = ST_BLANK;
            load     = 1'b1;
            load_val = LD_BLANK;
            col_d    = (col_q == LAST) ? '0 : col_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          col_d   = '0;
        end
      endcase
    end
    if (state_d == ST_SHOW) begin
      sel_d    = col_d + 1'b1;
      linhas_d = front_q[col_d];
      blank_d  = 1'b0;
    end
    fs_d = state_q == ST_BLANK && state_d == ST_SHOW
        && col_q == '0;
  end

  // A request at the consuming wrap re-arms for the next wrap.
  always_comb begin
    swap_pend_d = swap_pend_q | bus.swap_req;
    if (do_swap)
      swap_pend_d = bus.swap_req;
  end

  // Scan state, column and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      swap_pend_q <= 1'b0;
      sel_q       <= '0;
      linhas_q    <= '0;
      blank_q     <= 1'b1;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      swap_pend_q <= swap_pend_d;
      sel_q       <= sel_d;
      linhas_q    <= linhas_d;
      blank_q     <= blank_d;
      fs_q        <= fs_d;
    end
  end

  // Back takes host writes; front copies pre-edge back at swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COL; i++) begin
        front_q[i] <= '0;
        back_q[i]  <= '0;
      end
    end else begin
      if (bus.wr_en && bus.wr_col <= LAST)
        back_q[bus.wr_col] <= bus.wr_data;
      if (do_swap)
        front_q <= back_q;
    end
  end

  assign bus.sel         = sel_q;
  assign bus.linhas      = linhas_q;
  assign bus.blank       = blank_q;
  assign bus.frame_start = fs_q;
  assign bus.swap_pend   = swap_pend_q;

endmodule

// File: tb/tb_controlador_varredura.sv
// Directed bench for the column scanner, DWELL=3 BLANK=1.
// Each scan cycle is checked against a hand-built 4-cycle pattern.
module tb_controlador_varredura;
  import painel_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  controlador_varredura_if bus ();

  controlador_varredura #(
    .DWELL (3),
    .BLANK (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int col_of(input int k);
    return ((k - 1) / 4) % 7;
  endfunction

  function automatic int frm_of(input int k);
    return (k - 1) / 28;
  endfunction

  task automatic chk_cyc(input string tag, input int k,
                         input int lin, input int pend);
    int p;
    int c;
    string t;
    p = (k - 1) % 4;
    c = col_of(k);
    t = $sformatf("%s%0d", tag, k);
    chk({t, ".sel"}, 32'(bus.sel), (p == 0) ? 0 : c + 1);
    chk({t, ".lin"}, 32'(bus.linhas), (p == 0) ? 0 : lin);
    chk({t, ".blank"}, 32'(bus.blank), (p == 0) ? 1 : 0);
    chk({t, ".fs"}, 32'(bus.frame_start),
        (p == 1 && c == 0) ? 1 : 0);
    chk({t, ".pend"}, 32'(bus.swap_pend), pend);
  endtask

  task automatic chk_idle(input string tag, input int pend);
    chk({tag, ".sel"}, 32'(bus.sel), 0);
    chk({tag, ".lin"}, 32'(bus.linhas), 0);
    chk({tag, ".blank"}, 32'(bus.blank), 1);
    chk({tag, ".fs"}, 32'(bus.frame_start), 0);
    chk({tag, ".pend"}, 32'(bus.swap_pend), pend);
  endtask

  initial begin
    int f;
    int c;
    int lin;
    int pend;
    rst_n        = 1'b1;
    bus.en       = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_col   = '0;
    bus.wr_data  = '0;
    bus.swap_req = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_idle("rst", 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_col  = 3'(i);
      bus.wr_data = 7'(i + 1);
      @(negedge clk);
    end
    bus.wr_en    = 1'b0;
    bus.swap_req = 1'b1;
    @(negedge clk);
    chk_idle("req1", 1);
    @(negedge clk);
    bus.swap_req = 1'b0;
    chk_idle("req2", 1);
    bus.en = 1'b1;

    for (int k = 1; k <= 130; k++) begin
      @(posedge clk);
      @(negedge clk);
      f = frm_of(k);
      c = col_of(k);
      if (f == 0)
        lin = 0;
      else if (f <= 2)
        lin = c + 1;
      else
        lin = 'h40 + c;
      pend = (k < 29 || (k >= 57 && k < 85)) ? 1 : 0;
      chk_cyc("A", k, lin, pend);
      bus.wr_en    = 1'b0;
      bus.swap_req = 1'b0;
      if (k >= 39 && k <= 45) begin
        bus.wr_en   = 1'b1;
        bus.wr_col  = 3'(k - 39);
        bus.wr_data = 7'('h40 + k - 39);
      end
      if (k == 56)
        bus.swap_req = 1'b1;
      if (k == 84) begin
        bus.wr_en   = 1'b1;
        bus.wr_col  = 3'd0;
        bus.wr_data = 7'h55;
      end
      if (k == 130)
        bus.en = 1'b0;
    end

    @(negedge clk);
    chk_idle("off1", 0);
    @(negedge clk);
    chk_idle("off2", 0);
    bus.en       = 1'b1;
    bus.wr_en    = 1'b1;
    bus.wr_col   = 3'd7;
    bus.wr_data  = 7'h7F;
    bus.swap_req = 1'b1;

    for (int j = 1; j <= 31; j++) begin
      @(posedge clk);
      @(negedge clk);
      bus.wr_en    = 1'b0;
      bus.swap_req = 1'b0;
      f = frm_of(j);
      c = col_of(j);
      if (f == 0 || c != 0)
        lin = 'h40 + c;
      else
        lin = 'h55;
      chk_cyc("C", j, lin, (j < 29) ? 1 : 0);
    end

    rst_n = 1'b0;
    #1 chk_idle("midrst", 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int j = 1; j <= 6; j++) begin
      @(posedge clk);
      @(negedge clk);
      chk_cyc("D", j, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
